// File: rtl/inst_encoder.sv
// RV32I instruction encoder (I/S/B/J formats) with range-checked immediates and an output FIFO.
// Optional macro INST_ENC_ERR_CNT_EN adds a saturating err_count output.
module inst_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       fmt,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      inst_code,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count
`ifdef INST_ENC_ERR_CNT_EN
    ,
    output logic [7:0]       err_count
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

    localparam logic signed [31:0] IS_MIN = -32'sd2048;
    localparam logic signed [31:0] IS_MAX = 32'sd2047;
    localparam logic signed [31:0] B_MIN  = -32'sd4096;
    localparam logic signed [31:0] B_MAX  = 32'sd4094;
    localparam logic signed [31:0] J_MIN  = -32'sd1048576;
    localparam logic signed [31:0] J_MAX  = 32'sd1048574;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic signed [31:0] imm_s;
    logic [31:0]        enc_code;
    logic               enc_err;
    logic               push;
    logic               pop;

    logic [32:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;

    assign imm_s = imm;

    // Pack the fields for the selected format; unencodable requests become a NOP flagged as error.
    always_comb begin
        enc_code = '0;
        enc_err  = 1'b0;
        case (fmt)
            3'd0, 3'd1: begin
                enc_err  = (imm_s < IS_MIN) || (imm_s > IS_MAX);
                enc_code = {imm[11:0], rs1, funct3, rd,
                            (fmt == 3'd0) ? 7'b0000011 : 7'b0010011};
            end
            3'd2: begin
                enc_err  = (imm_s < IS_MIN) || (imm_s > IS_MAX);
                enc_code = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
            end
            3'd3: begin
                enc_err  = (imm_s < B_MIN) || (imm_s > B_MAX) || imm[0];
                enc_code = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
            end
            3'd4: begin
                enc_err  = (imm_s < J_MIN) || (imm_s > J_MAX) || imm[0];
                enc_code = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            end
            default: begin
                enc_err = 1'b1;
            end
        endcase
        if (enc_err) begin
            enc_code = NOP;
        end
    end

    assign in_ready  = (occ != FULL_OCC);
    assign out_valid = (occ != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    assign inst_code = out_valid ? mem[rd_ptr][31:0] : '0;
    assign out_err   = out_valid ? mem[rd_ptr][32]   : 1'b0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {enc_err, enc_code};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count <= '0;
        end else if (push && (enc_count != '1)) begin
            enc_count <= enc_count + CNT_W'(1);
        end
    end

`ifdef INST_ENC_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (push && enc_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed vectors, backpressure/reset scenarios,
// then randomized traffic against a queue-based reference model.
module tb_inst_encoder;

    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       fmt;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic [31:0]      imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      inst_code;
    logic             out_err;
    logic [CNT_W-1:0] enc_count;
`ifdef INST_ENC_ERR_CNT_EN
    logic [7:0]       err_count;
    int               exp_err_cnt;
`endif

    int tests_run;
    int tests_failed;

    logic [32:0] model_q[$];
    int          exp_cnt;

    inst_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inst_code (inst_code),
        .out_err   (out_err),
        .enc_count (enc_count)
`ifdef INST_ENC_ERR_CNT_EN
        ,
        .err_count (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference encoder: range rules on the integer value, fields placed by shift-and-mask.
    function automatic logic [32:0] refEncode(input logic [2:0] f, input logic [4:0] d,
                                              input logic [4:0] s1, input logic [4:0] s2,
                                              input logic [2:0] f3, input logic [31:0] im);
        int          v;
        int unsigned u;
        int unsigned code;
        int unsigned opc;
        bit          ok;
        v = $signed(im);
        u = im;
        ok = 1'b0;
        code = 0;
        case (f)
            3'd0, 3'd1: begin
                opc  = (f == 3'd0) ? 32'h03 : 32'h13;
                ok   = (v >= -2048) && (v <= 2047);
                code = ((u & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7) | opc;
            end
            3'd2: begin
                ok   = (v >= -2048) && (v <= 2047);
                code = (((u >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | (32'(s1) << 15)
                     | (32'(f3) << 12) | ((u & 32'h1F) << 7) | 32'h23;
            end
            3'd3: begin
                ok   = (v >= -4096) && (v <= 4094) && ((u % 2) == 0);
                code = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(s2) << 20)
                     | (32'(s1) << 15) | (32'(f3) << 12) | (((u >> 1) & 32'hF) << 8)
                     | (((u >> 11) & 1) << 7) | 32'h63;
            end
            3'd4: begin
                ok   = (v >= -1048576) && (v <= 1048574) && ((u % 2) == 0);
                code = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 1) << 20)
                     | (((u >> 12) & 32'hFF) << 12) | (32'(d) << 7) | 32'h6F;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) code = 32'h13;
        return {~ok, code};
    endfunction

    task automatic setFields(input logic [2:0] f, input logic [4:0] d, input logic [4:0] s1,
                             input logic [4:0] s2, input logic [2:0] f3, input logic [31:0] im);
        fmt = f; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; imm = im;
    endtask

    // One request into an empty FIFO with out_ready high; returns at the negedge after acceptance.
    task automatic applyStimulus(input logic [2:0] f, input logic [4:0] d, input logic [4:0] s1,
                                 input logic [4:0] s2, input logic [2:0] f3, input logic [31:0] im);
        @(negedge clk);
        setFields(f, d, s1, s2, f3, im);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        setFields(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_inst_code", inst_code, 32'h0);
        checkOutput("rst_out_err", out_err, 1'b0);
        checkOutput("rst_enc_count", enc_count, 0);
        checkOutput("rst_in_ready", in_ready, 1'b1);

        applyStimulus(3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF);
        checkOutput("opimm_valid", out_valid, 1'b1);
        checkOutput("opimm_code", inst_code, 32'hFFF00293);
        checkOutput("opimm_err", out_err, 1'b0);
        checkOutput("opimm_count", enc_count, 1);

        applyStimulus(3'd2, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);
        checkOutput("store_code", inst_code, 32'h0020A423);
        applyStimulus(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd4);
        checkOutput("branch_code", inst_code, 32'hFE000EE3);
        applyStimulus(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
        checkOutput("jal_code", inst_code, 32'h001000EF);
        checkOutput("jal_err", out_err, 1'b0);
        applyStimulus(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3);
        checkOutput("odd_branch_code", inst_code, 32'h00000013);
        checkOutput("odd_branch_err", out_err, 1'b1);
        applyStimulus(3'd0, 5'd3, 5'd4, 5'd0, 3'd2, 32'd2048);
        checkOutput("load_range_err", out_err, 1'b1);
        checkOutput("load_range_code", inst_code, 32'h00000013);
        checkOutput("directed_count", enc_count, 6);
`ifdef INST_ENC_ERR_CNT_EN
        checkOutput("directed_err_count", err_count, 2);
`endif

        // Backpressure: two accepts fill the FIFO, third waits for space.
        @(negedge clk);
        out_ready = 1'b0;
        setFields(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0);
        in_valid = 1'b1;
        @(negedge clk);
        checkOutput("bp_head_a", inst_code, 32'h00000093);
        setFields(3'd1, 5'd2, 5'd0, 5'd0, 3'd0, 32'd0);
        @(negedge clk);
        checkOutput("bp_full_ready", in_ready, 1'b0);
        setFields(3'd1, 5'd3, 5'd0, 5'd0, 3'd0, 32'd0);
        @(negedge clk);
        checkOutput("bp_full_ready2", in_ready, 1'b0);
        checkOutput("bp_head_stable", inst_code, 32'h00000093);
        checkOutput("bp_count2", enc_count, 8);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_head_b", inst_code, 32'h00000113);
        checkOutput("bp_no_push_when_full", enc_count, 8);
        checkOutput("bp_ready_after_pop", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("bp_head_c", inst_code, 32'h00000193);
        checkOutput("bp_count3", enc_count, 9);
        @(negedge clk);
        checkOutput("bp_drained", out_valid, 1'b0);

        // Push and pop together at occupancy 1 keeps occupancy at 1.
        out_ready = 1'b0;
        setFields(3'd1, 5'd4, 5'd0, 5'd0, 3'd0, 32'd0);
        in_valid = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        setFields(3'd1, 5'd6, 5'd0, 5'd0, 3'd0, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("pp_head", inst_code, 32'h00000313);
        checkOutput("pp_ready", in_ready, 1'b1);
        @(negedge clk);
        checkOutput("pp_single_entry", out_valid, 1'b0);

        // Reset with two entries queued.
        out_ready = 1'b0;
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", out_valid, 1'b0);
        checkOutput("mid_rst_count", enc_count, 0);
        checkOutput("mid_rst_code", inst_code, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF);
        checkOutput("post_rst_valid", out_valid, 1'b1);
        checkOutput("post_rst_code", inst_code, 32'hFFF00293);
        checkOutput("post_rst_count", enc_count, 1);

        // Randomized traffic against the queue model.
        doReset();
        model_q.delete();
        exp_cnt = 0;
`ifdef INST_ENC_ERR_CNT_EN
        exp_err_cnt = 0;
`endif
        for (int c = 0; c < 500; c++) begin
            logic [32:0] ent;
            bit          exp_ready;
            bit          do_push;
            bit          do_pop;
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       imm = $urandom;
                1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                2:       imm = 32'($urandom_range(0, 32'h3FFFFF)) - 32'h200000;
                default: imm = 32'($urandom_range(0, 4200)) - 32'd2100;
            endcase
            fmt = 3'($urandom_range(0, 7));
            rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); funct3 = 3'($urandom);
            exp_ready = (model_q.size() < DEPTH);
            checkOutput("rnd_in_ready", in_ready, exp_ready);
            checkOutput("rnd_out_valid", out_valid, model_q.size() > 0);
            if (model_q.size() > 0) begin
                checkOutput("rnd_inst_code", inst_code, model_q[0][31:0]);
                checkOutput("rnd_out_err", out_err, model_q[0][32]);
            end
            checkOutput("rnd_enc_count", enc_count, exp_cnt);
`ifdef INST_ENC_ERR_CNT_EN
            checkOutput("rnd_err_count", err_count, exp_err_cnt);
`endif
            ent = refEncode(fmt, rd, rs1, rs2, funct3, imm);
            do_push = in_valid && exp_ready;
            do_pop = (model_q.size() > 0) && out_ready;
            @(posedge clk);
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                model_q.push_back(ent);
                if (exp_cnt < 65535) exp_cnt++;
`ifdef INST_ENC_ERR_CNT_EN
                if (ent[32] && exp_err_cnt < 255) exp_err_cnt++;
`endif
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Instruction encoder: packs format, register, funct3 and signed immediate fields into a 32-bit RV32I instruction word.
- Inverse of the immediate-extraction path; covers the I/S/B/J formats the decode path understands.
- Sits between the self-test/program-load sequencer and instruction memory write port.
- Valid/ready input, buffered valid/ready output, range checking of immediates, count of encoded words.

Parameters:
- DEPTH, 2, output FIFO entries; power of two, >= 2.
- CNT_W, 16, width of enc_count.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request fields valid.
- in_ready  output  1  encoder can accept; equals FIFO not full (no combinational dependence on out_ready).
- fmt  input  3  0=LOAD(0000011), 1=OP-IMM(0010011), 2=STORE(0100011), 3=BRANCH(1100011), 4=JAL(1101111), 5-7 invalid.
- rd, rs1, rs2  input  5 each  register indices.
- funct3  input  3  funct3 field.
- imm  input  32  signed byte-offset/immediate, two's complement.
- out_valid  output  1  inst_code/out_err valid.
- out_ready  input  1  consumer accepts.
- inst_code  output  32  encoded instruction.
- out_err  output  1  request was unencodable; inst_code is NOP.
- enc_count  output  CNT_W  accepted requests, saturating.

Behaviour:
- Reset (async assert, sync release): FIFO empty, out_valid=0, inst_code=0, out_err=0, enc_count=0, in_ready=1 after release.
- Accept when in_valid&&in_ready; encoding is combinational on inputs, result written to FIFO tail the same edge; out_valid rises next cycle (latency 1).
- Pop when out_valid&&out_ready; inst_code/out_err show FIFO head, held stable while out_valid&&!out_ready.
- Simultaneous push and pop: allowed at any occupancy except push is blocked when full (in_ready=0), even if out_ready=1 that cycle; count unchanged on push+pop.
- Order strictly preserved; read/write pointers wrap modulo DEPTH; occupancy counter 0..DEPTH.
- Encoding: I (fmt 0,1): {imm[11:0],rs1,funct3,rd,opc}. S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opc}. B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opc}. J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opc}. Unused fields ignored.
- Range rules (error otherwise): I/S imm in [-2048,2047]; B imm in [-4096,4094] and imm[0]=0; J imm in [-1048576,1048574] and imm[0]=0; fmt 5-7 always error.
- On error: entry stored as inst_code=32'h0000_0013, out_err=1; still counts as accepted.
- enc_count +1 per accept, saturates at all-ones, no wrap.
- Reset mid-operation: FIFO contents discarded, outputs to reset values immediately.

Optional Feature:
- Macro INST_ENC_ERR_CNT_EN.
- Defined: extra output port err_count (8 bits), increments on each accepted erroneous request, saturates at 255, reset to 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- fmt=1, rd=5, rs1=0, funct3=0, imm=-1, out_ready=1 -> next cycle out_valid=1, inst_code=32'hFFF00293, out_err=0, enc_count=1.
- fmt=2, rs1=1, rs2=2, funct3=2, imm=8 -> inst_code=32'h0020A423; fmt=3, rs1=rs2=0, funct3=0, imm=-4 -> 32'hFE000EE3.
- fmt=4, rd=1, imm=2048 -> 32'h001000EF; fmt=3, imm=3 -> inst_code=32'h00000013, out_err=1 (err_count=1 with macro); fmt=0, imm=2048 -> error.
- out_ready=0, offer 3 back-to-back requests -> in_ready=0 after 2 accepts, head stable; raise out_ready -> entries drain in order, third accepted once space frees, enc_count=3.
- Full FIFO with in_valid=1, out_ready=1 -> pop only that cycle, push next cycle; half-full push+pop -> occupancy unchanged.
- rst_n low with 2 entries queued -> out_valid=0, enc_count=0 immediately; after release first new request emerges with latency 1.
